// File: rtl/axi_vdma_pkg.sv
// Shared constants and state encoding for the VDMA write-burst controller.
package axi_vdma_pkg;

  localparam int BYTES_PER_BEAT = 32;
  localparam int BOUNDARY_4K    = 4096;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    REQ       = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4,
    ERR       = 3'd5
  } vdma_state_e;

endpackage

// File: rtl/axi_vdma_watchdog.sv
// Per-burst watchdog: counts enabled cycles since the last clear, flags TIMEOUT.
module axi_vdma_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic axi_aclk,
  input  logic axi_resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT));

  // Parks at TIMEOUT so a late expiry cannot wrap back to zero.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axi_vdma_wr_burst_ctrl.sv
// Splits a video frame into AXI write bursts that never cross 4 KB,
// gated on upstream FIFO fill and guarded by a per-burst watchdog.
module axi_vdma_wr_burst_ctrl
  import axi_vdma_pkg::*;
#(
  parameter int ASIZE     = 32,
  parameter int LSIZE     = 10,
  parameter int CSIZE     = 24,
  parameter int FSIZE     = 12,
  parameter int BURST_LEN = 256,
  parameter int TIMEOUT   = 65535
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             frame_start,
  input  logic [ASIZE-1:0] frame_base,
  input  logic [CSIZE-1:0] frame_beats,
  input  logic [FSIZE-1:0] fifo_count,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic             write_req,
  output logic [LSIZE-1:0] req_len,
  output logic [ASIZE-1:0] req_addr,
  input  logic             req_resp,
  input  logic             req_done
);

  // state     | meaning
  // IDLE      | no frame, waiting for frame_start
  // WAIT_DATA | waiting for FIFO to hold next_len beats
  // REQ       | write_req asserted, waiting for req_resp
  // WAIT_DONE | burst issued, waiting for req_done
  // DONE      | frame_done pulse
  // ERR       | frame_err pulse after watchdog expiry

  vdma_state_e      state_q, state_d;
  logic [ASIZE-1:0] cur_addr, addr_nxt;
  logic [CSIZE-1:0] remaining, rem_nxt;
  logic [LSIZE-1:0] next_len;
  logic             enter_req;
  logic             wd_en, wd_expired;
  logic             write_req_d, frame_busy_d, frame_done_d, frame_err_d;

  function automatic logic [LSIZE-1:0] calc_len(input logic [11:0]      offs,
                                                input logic [CSIZE-1:0] rem);
    logic [12:0] room_beats;
    logic [31:0] lim;
    room_beats = (13'(BOUNDARY_4K) - {1'b0, offs}) / 13'(BYTES_PER_BEAT);
    lim = 32'(BURST_LEN);
    if (32'(room_beats) < lim) lim = 32'(room_beats);
    if (32'(rem) < lim) lim = 32'(rem);
    return LSIZE'(lim);
  endfunction

  assign addr_nxt  = cur_addr + ASIZE'(req_len) * ASIZE'(BYTES_PER_BEAT);
  assign rem_nxt   = remaining - CSIZE'(req_len);
  assign enter_req = (state_d == REQ) && (state_q != REQ);
  assign wd_en     = (state_q == REQ) || (state_q == WAIT_DONE);

  axi_vdma_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .clear      (enter_req),
    .enable     (wd_en),
    .expired    (wd_expired)
  );

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A completing burst wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = (frame_beats == '0) ? DONE : WAIT_DATA;
      end
      WAIT_DATA: begin
        if (32'(fifo_count) >= 32'(next_len)) state_d = REQ;
      end
      REQ: begin
        if (wd_expired)    state_d = ERR;
        else if (req_resp) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (req_done)        state_d = (rem_nxt == '0) ? DONE : WAIT_DATA;
        else if (wd_expired) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_req_d  = (state_d == REQ);
    frame_busy_d = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    frame_err_d  = (state_d == ERR);
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      write_req  <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      write_req  <= write_req_d;
      frame_busy <= frame_busy_d;
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
    end
  end

  // next_len is recomputed alongside every cur_addr/remaining update so it is
  // already valid on the first WAIT_DATA cycle.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cur_addr  <= '0;
      remaining <= '0;
      next_len  <= '0;
      req_len   <= '0;
      req_addr  <= '0;
    end else begin
      if (state_q == IDLE && frame_start) begin
        cur_addr  <= frame_base;
        remaining <= frame_beats;
        next_len  <= calc_len(frame_base[11:0], frame_beats);
      end
      if (enter_req) begin
        req_len  <= next_len;
        req_addr <= cur_addr;
      end
      if (state_q == WAIT_DONE && req_done) begin
        cur_addr  <= addr_nxt;
        remaining <= rem_nxt;
        next_len  <= calc_len(addr_nxt[11:0], rem_nxt);
      end
    end
  end

endmodule

// File: doc/axi_vdma_wr_burst_ctrl.md
AXI_VDMA_WR_BURST_CTRL -- requirements
Module: axi_vdma_wr_burst_ctrl

Interface
REQ-001 SHALL have parameter ASIZE, default 32, the address width.
REQ-002 SHALL have parameter LSIZE, default 10, the req_len width.
REQ-003 SHALL have parameter CSIZE, default 24, the frame beat-count width.
REQ-004 SHALL have parameter FSIZE, default 12, the fifo_count width.
REQ-005 SHALL have parameter BURST_LEN, default 256, the maximum beats per burst.
REQ-006 SHALL have parameter TIMEOUT, default 65535, the watchdog cycle limit per burst.
REQ-007 SHALL have the following ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  reset; one clock, asynchronous, active-low.
- frame_start  in  1  one-cycle frame request.
- frame_base  in  ASIZE  start byte address; 32-byte aligned.
- frame_beats  in  CSIZE  total beats in the frame.
- fifo_count  in  FSIZE  beats available in the upstream write-data FIFO.
- frame_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse on frame completion.
- frame_err  out  1  one-cycle pulse on watchdog abort.
- write_req  out  1  burst request to the write state core.
- req_len  out  LSIZE  burst length in beats (1..BURST_LEN).
- req_addr  out  ASIZE  burst start byte address.
- req_resp  in  1  core accepted the request (AW phase issued).
- req_done  in  1  core burst completed with OKAY response.

Function
REQ-008 SHALL implement states IDLE, WAIT_DATA, REQ, WAIT_DONE, DONE, ERR.
REQ-009 SHALL act on frame_start only in IDLE; frame_start in any other state SHALL be ignored.
REQ-010 SHALL, in IDLE, capture frame_base to cur_addr and frame_beats to remaining on frame_start.
REQ-011 SHALL, on frame_start, go to WAIT_DATA, or to DONE when frame_beats==0.
REQ-012 SHALL compute next_len = min(BURST_LEN, remaining, (4096 - cur_addr[11:0])/32).
REQ-013 SHALL register next_len, so that no burst crosses a 4 KB boundary.
REQ-014 SHALL, in WAIT_DATA, go to REQ when fifo_count >= next_len; otherwise it SHALL stay in WAIT_DATA.
REQ-015 SHALL, in REQ, assert write_req registered.
REQ-016 SHALL hold write_req until req_resp is sampled high, then deassert it next cycle and go to WAIT_DONE.
REQ-017 SHALL hold req_len and req_addr stable from write_req rise until req_done.
REQ-018 SHALL, in WAIT_DONE on req_done, set cur_addr += req_len*32 and remaining -= req_len.
REQ-019 SHALL, on that req_done, go to DONE if the new remaining is 0, else to WAIT_DATA.
REQ-020 SHALL clear the watchdog counter on entry to REQ and increment it each cycle in REQ/WAIT_DONE.
REQ-021 SHALL go to ERR when the watchdog counter reaches TIMEOUT; watchdog expiry and req_done in the same cycle SHALL resolve in favour of req_done.
REQ-022 SHALL, in DONE, pulse frame_done for one cycle and return to IDLE; in ERR, pulse frame_err for one cycle, force write_req low and return to IDLE.
REQ-023 SHALL hold frame_busy high in all states except IDLE, registered.
REQ-024 SHALL perform address arithmetic modulo 2^ASIZE, with no saturation.

Reset
REQ-025 SHALL, while axi_resetn is low, asynchronously force state IDLE and write_req, frame_busy, frame_done, frame_err, req_len, req_addr, remaining and watchdog to 0.
REQ-026 SHALL, on reset mid-burst, discard the frame without a frame_done or frame_err pulse.

Structure
REQ-027 SHALL place BYTES_PER_BEAT=32, BOUNDARY_4K=4096 and the state encodings in the shared package axi_vdma_pkg.
REQ-028 SHALL implement the watchdog as sub-module axi_vdma_watchdog (clear, enable, TIMEOUT parameter, expired output).

Verification
REQ-029 base 0x0, beats 512, fifo_count 1023, immediate req_resp/req_done -> bursts (0x0000,128),(0x1000,128),(0x2000,128),(0x3000,128), then one frame_done.
REQ-030 base 0x0F00, beats 20 -> bursts (0x0F00,8),(0x1000,12), then frame_done.
REQ-031 beats 0 -> frame_done one cycle after frame_start, write_req never asserted.
REQ-032 next_len 128 with fifo_count 100 -> write_req stays low; fifo_count raised to 128 -> write_req high within 2 cycles.
REQ-033 TIMEOUT=64, req_done withheld -> frame_err pulse at cycle 64, write_req and frame_busy low, next frame_start accepted.
REQ-034 axi_resetn low during WAIT_DONE -> all outputs 0 immediately; no frame_done after release.
